// File: rtl/ghost_move_ctrl.sv
// ghost_move_ctrl: tile-grid movement controller for one ghost.
// Every SPEED_DIV frame ticks it probes the neighbour tiles through a shared
// wall-query port, picks the legal direction closest to the target tile and
// advances one tile. Position/direction feed the ghost sprite renderer.
module ghost_move_ctrl #(
    parameter int unsigned SPEED_DIV = 8,
    parameter int unsigned MAZE_W    = 28,
    parameter int unsigned MAZE_H    = 31,
    parameter int unsigned START_X   = 13,
    parameter int unsigned START_Y   = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       run,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic       qry_valid,
    output logic [4:0] qry_x,
    output logic [4:0] qry_y,
    input  logic       qry_ready,
    input  logic       rsp_valid,
    input  logic       rsp_wall,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       busy,
    output logic       step_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PROBE  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_MOVE   = 3'd4
    } state_t;

    // Sub-phase of one candidate probe: issue, wait for accept, wait for response.
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_REQ   = 2'd1,
        PH_RSP   = 2'd2
    } phase_t;

    typedef struct packed {
        logic       oob;
        logic [4:0] x;
        logic [4:0] y;
    } nbr_t;

    localparam logic [4:0] X_MAX     = 5'(MAZE_W - 1);
    localparam logic [4:0] Y_MAX     = 5'(MAZE_H - 1);
    localparam logic [3:0] TICK_LAST = 4'(SPEED_DIV - 1);
    localparam logic [4:0] X_RST     = 5'(START_X);
    localparam logic [4:0] Y_RST     = 5'(START_Y);

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Opposite direction: the encoding makes this a bitwise inversion.
    function automatic logic [1:0] rev_dir(input logic [1:0] d);
        return ~d;
    endfunction

    // Candidate index -> direction, in tie-break order up, left, down, right.
    function automatic logic [1:0] cand_dir(input logic [1:0] idx);
        logic [1:0] d;
        case (idx)
            2'd0:    d = DIR_UP;
            2'd1:    d = DIR_LEFT;
            2'd2:    d = DIR_DOWN;
            2'd3:    d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

    // Neighbour tile in direction d. x wraps through the tunnel; y off the
    // maze is flagged out-of-bounds and treated as a wall by the caller.
    function automatic nbr_t neighbour(input logic [4:0] x, input logic [4:0] y,
                                       input logic [1:0] d);
        nbr_t n;
        n.oob = 1'b0;
        n.x   = x;
        n.y   = y;
        case (d)
            DIR_RIGHT: n.x = (x >= X_MAX) ? 5'd0 : x + 5'd1;
            DIR_LEFT:  n.x = (x == 5'd0) ? X_MAX : x - 5'd1;
            DIR_UP: begin
                if (y == 5'd0) begin
                    n.oob = 1'b1;
                end else begin
                    n.y = y - 5'd1;
                end
            end
            DIR_DOWN: begin
                if (y >= Y_MAX) begin
                    n.oob = 1'b1;
                end else begin
                    n.y = y + 5'd1;
                end
            end
            default: n.oob = 1'b0;
        endcase
        return n;
    endfunction

    // Squared euclidean distance from 6-bit signed differences (max 1922).
    function automatic logic [10:0] tile_dist(input logic [4:0] nx, input logic [4:0] ny,
                                              input logic [4:0] tx, input logic [4:0] ty);
        logic [5:0]  dx;
        logic [5:0]  dy;
        logic [5:0]  adx;
        logic [5:0]  ady;
        logic [10:0] sx;
        logic [10:0] sy;
        dx  = {1'b0, nx} - {1'b0, tx};
        dy  = {1'b0, ny} - {1'b0, ty};
        adx = dx[5] ? (6'd0 - dx) : dx;
        ady = dy[5] ? (6'd0 - dy) : dy;
        sx  = {5'd0, adx};
        sy  = {5'd0, ady};
        return (sx * sx) + (sy * sy);
    endfunction

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [1:0] cand_idx_q, cand_idx_d;
    logic [3:0] legal_q, legal_d;
    logic [3:0] tick_q, tick_d;
    logic       pending_q, pending_d;
    logic       qry_valid_q, qry_valid_d;
    logic [4:0] qry_x_q, qry_x_d;
    logic [4:0] qry_y_q, qry_y_d;
    logic [4:0] xpos_q, xpos_d;
    logic [4:0] ypos_q, ypos_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] new_dir_q, new_dir_d;
    logic       busy_q, busy_d;
    logic       step_done_q, step_done_d;

    logic        tick_wrap_s;
    logic        pending_clr_s;
    logic        advance_s;
    logic [1:0]  cand_s;
    nbr_t        cand_nbr_s;
    nbr_t        move_nbr_s;
    logic        best_found_s;
    logic [10:0] best_dist_s;
    logic [1:0]  best_dir_s;
    logic [1:0]  scan_dir_s;
    nbr_t        scan_nbr_s;
    logic [10:0] scan_dist_s;

    // Direction choice: minimum distance over legal candidates, earliest wins ties; dead end reverses.
    always_comb begin
        best_found_s = 1'b0;
        best_dist_s  = 11'h7FF;
        best_dir_s   = rev_dir(dir_q);
        scan_dir_s   = DIR_UP;
        scan_nbr_s   = nbr_t'(11'd0);
        scan_dist_s  = 11'd0;
        for (int i = 0; i < 4; i++) begin
            scan_dir_s  = cand_dir(2'(i));
            scan_nbr_s  = neighbour(xpos_q, ypos_q, scan_dir_s);
            scan_dist_s = tile_dist(scan_nbr_s.x, scan_nbr_s.y, target_x, target_y);
            if (legal_q[i] && (!best_found_s || (scan_dist_s < best_dist_s))) begin
                best_found_s = 1'b1;
                best_dist_s  = scan_dist_s;
                best_dir_s   = scan_dir_s;
            end else begin
                best_found_s = best_found_s;
            end
        end
    end

    // Next-state logic: tick divider, step FSM, probe handshake and position update.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cand_idx_d    = cand_idx_q;
        legal_d       = legal_q;
        tick_d        = tick_q;
        qry_valid_d   = qry_valid_q;
        qry_x_d       = qry_x_q;
        qry_y_d       = qry_y_q;
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        dir_d         = dir_q;
        new_dir_d     = new_dir_q;
        step_done_d   = 1'b0;
        tick_wrap_s   = 1'b0;
        pending_clr_s = 1'b0;
        advance_s     = 1'b0;
        cand_s        = cand_dir(cand_idx_q);
        cand_nbr_s    = neighbour(xpos_q, ypos_q, cand_s);
        move_nbr_s    = neighbour(xpos_q, ypos_q, new_dir_q);

        if ((state_q != ST_IDLE) && ce) begin
            if (tick_q >= TICK_LAST) begin
                tick_d      = 4'd0;
                tick_wrap_s = 1'b1;
            end else begin
                tick_d = tick_q + 4'd1;
            end
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d       = ST_WAIT;
                    tick_d        = 4'd0;
                    pending_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (pending_q) begin
                    state_d       = ST_PROBE;
                    phase_d       = PH_ISSUE;
                    cand_idx_d    = 2'd0;
                    legal_d       = 4'd0;
                    pending_clr_s = 1'b1;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PROBE: begin
                case (phase_q)
                    PH_ISSUE: begin
                        // Reverse and off-maze candidates are settled without a query.
                        if ((cand_s == rev_dir(dir_q)) || cand_nbr_s.oob) begin
                            legal_d[cand_idx_q] = 1'b0;
                            advance_s           = 1'b1;
                        end else begin
                            qry_valid_d = 1'b1;
                            qry_x_d     = cand_nbr_s.x;
                            qry_y_d     = cand_nbr_s.y;
                            phase_d     = PH_REQ;
                        end
                    end
                    PH_REQ: begin
                        if (qry_ready) begin
                            qry_valid_d = 1'b0;
                            if (rsp_valid) begin
                                legal_d[cand_idx_q] = ~rsp_wall;
                                advance_s           = 1'b1;
                            end else begin
                                phase_d = PH_RSP;
                            end
                        end else begin
                            qry_valid_d = 1'b1;
                        end
                    end
                    PH_RSP: begin
                        if (rsp_valid) begin
                            legal_d[cand_idx_q] = ~rsp_wall;
                            advance_s           = 1'b1;
                        end else begin
                            phase_d = PH_RSP;
                        end
                    end
                    default: phase_d = PH_ISSUE;
                endcase
                if (advance_s) begin
                    phase_d = PH_ISSUE;
                    if (cand_idx_q == 2'd3) begin
                        state_d = ST_DECIDE;
                    end else begin
                        cand_idx_d = cand_idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_PROBE;
                end
            end
            ST_DECIDE: begin
                new_dir_d = best_dir_s;
                state_d   = ST_MOVE;
            end
            ST_MOVE: begin
                dir_d = new_dir_q;
                if (!move_nbr_s.oob) begin
                    xpos_d = move_nbr_s.x;
                    ypos_d = move_nbr_s.y;
                end else begin
                    xpos_d = xpos_q;
                    ypos_d = ypos_q;
                end
                step_done_d = 1'b1;
                if (run) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A period boundary always re-arms; pending saturates at one.
        pending_d = tick_wrap_s | (pending_q & ~pending_clr_s);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops the query request immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ISSUE;
            cand_idx_q  <= 2'd0;
            legal_q     <= 4'd0;
            tick_q      <= 4'd0;
            pending_q   <= 1'b0;
            qry_valid_q <= 1'b0;
            qry_x_q     <= 5'd0;
            qry_y_q     <= 5'd0;
            xpos_q      <= X_RST;
            ypos_q      <= Y_RST;
            dir_q       <= DIR_LEFT;
            new_dir_q   <= DIR_LEFT;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cand_idx_q  <= cand_idx_d;
            legal_q     <= legal_d;
            tick_q      <= tick_d;
            pending_q   <= pending_d;
            qry_valid_q <= qry_valid_d;
            qry_x_q     <= qry_x_d;
            qry_y_q     <= qry_y_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            dir_q       <= dir_d;
            new_dir_q   <= new_dir_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
        end
    end

    assign qry_valid = qry_valid_q;
    assign qry_x     = qry_x_q;
    assign qry_y     = qry_y_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign direction = dir_q;
    assign busy      = busy_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Directed bench for ghost_move_ctrl: a small maze-arbiter model answers wall
// queries from a bench wall map; expected steps go to a scoreboard queue and
// are checked when step_done pulses.
module tb_ghost_move_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       run;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic       qry_valid;
    logic [4:0] qry_x;
    logic [4:0] qry_y;
    logic       qry_ready;
    logic       rsp_valid;
    logic       rsp_wall;
    logic [4:0] xpos;
    logic [4:0] ypos;
    logic [1:0] direction;
    logic       busy;
    logic       step_done;

    int checks   = 0;
    int failures = 0;

    // wall map, wmap[y][x] = 1 means wall
    logic       wmap [0:31][0:31];
    logic [9:0] qlog [$];
    logic [11:0] exp_q [$];
    int  steps_seen  = 0;
    int  nexp        = 0;
    int  ready_delay = 0;
    int  rsp_delay   = 0;
    int  stab_err    = 0;
    int  rdy_cnt     = 0;
    int  rsp_cnt     = 0;
    bit  outstanding = 1'b0;
    logic       q_wall;
    logic [4:0] hold_x;
    logic [4:0] hold_y;

    always #5 clk = ~clk;

    ghost_move_ctrl #(
        .SPEED_DIV(8), .MAZE_W(28), .MAZE_H(31), .START_X(13), .START_Y(11)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .run(run),
        .target_x(target_x), .target_y(target_y),
        .qry_valid(qry_valid), .qry_x(qry_x), .qry_y(qry_y), .qry_ready(qry_ready),
        .rsp_valid(rsp_valid), .rsp_wall(rsp_wall),
        .xpos(xpos), .ypos(ypos), .direction(direction),
        .busy(busy), .step_done(step_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic ce_pulse(input int n);
        repeat (n) begin
            @(negedge clk); ce = 1'b1;
            @(negedge clk); ce = 1'b0;
        end
    endtask

    task automatic ce_burst(input int n);
        @(negedge clk); ce = 1'b1;
        repeat (n) @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic wait_steps(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((steps_seen < n) && (c < budget)) begin
            @(negedge clk); #1;
            c++;
        end
        check(tag, steps_seen, n);
    endtask

    // Arbiter model: optional ready stall, response same cycle or rsp_delay later.
    initial begin
        qry_ready = 1'b0; rsp_valid = 1'b0; rsp_wall = 1'b0;
        forever begin
            @(negedge clk);
            qry_ready = 1'b0; rsp_valid = 1'b0; rsp_wall = 1'b0;
            if (reset_n !== 1'b1) begin
                outstanding = 1'b0; rdy_cnt = 0;
            end else if (outstanding) begin
                rsp_cnt++;
                if (rsp_cnt >= rsp_delay) begin
                    rsp_valid = 1'b1; rsp_wall = q_wall; outstanding = 1'b0;
                end
            end else if (qry_valid === 1'b1) begin
                if (rdy_cnt == 0) begin
                    hold_x = qry_x; hold_y = qry_y;
                end else if ((qry_x !== hold_x) || (qry_y !== hold_y)) begin
                    stab_err++;
                end
                if (rdy_cnt >= ready_delay) begin
                    qry_ready = 1'b1; rdy_cnt = 0;
                    q_wall = wmap[qry_y][qry_x];
                    qlog.push_back({qry_x, qry_y});
                    if (rsp_delay == 0) begin
                        rsp_valid = 1'b1; rsp_wall = q_wall;
                    end else begin
                        outstanding = 1'b1; rsp_cnt = 0;
                    end
                end else begin
                    rdy_cnt++;
                end
            end
        end
    end

    // Scoreboard: each step_done pops one expected {x, y, dir}.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (step_done === 1'b1) begin
                steps_seen++;
                if (exp_q.size() == 0) begin
                    check("step_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("step_x", 32'(xpos), 32'(e[11:7]));
                    check("step_y", 32'(ypos), 32'(e[6:2]));
                    check("step_dir", 32'(direction), 32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ce = 1'b0; run = 1'b0;
        target_x = 5'd0; target_y = 5'd11;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                wmap[y][x] = 1'b1;
        for (int x = 0; x < 28; x++) wmap[11][x] = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_xpos", 32'(xpos), 32'd13);
        check("rst_ypos", 32'(ypos), 32'd11);
        check("rst_dir", 32'(direction), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_qry_valid", 32'(qry_valid), 32'd0);
        check("rst_step_done", 32'(step_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("run_busy", 32'(busy), 32'd1);

        // open corridor: 7 ticks do nothing, the 8th triggers one step left
        qlog.delete();
        ce_pulse(7);
        #1;
        check("no_step_early", steps_seen, 0);
        check("no_query_early", 32'(qlog.size()), 32'd0);
        exp_q.push_back({5'd12, 5'd11, 2'd3}); nexp++;
        ce_pulse(1);
        wait_steps(nexp, 40, "corridor_step");
        check("corridor_nq", 32'(qlog.size()), 32'd3);
        if (qlog.size() == 3) begin
            check("corridor_q_up", 32'(qlog[0]), 32'({5'd13, 5'd10}));
            check("corridor_q_left", 32'(qlog[1]), 32'({5'd12, 5'd11}));
            check("corridor_q_down", 32'(qlog[2]), 32'({5'd13, 5'd12}));
        end

        // walk the corridor down to x=0
        for (int k = 11; k >= 0; k--) begin
            qlog.delete();
            exp_q.push_back({5'(k), 5'd11, 2'd3}); nexp++;
            ce_pulse(8);
            wait_steps(nexp, 40, "walk_step");
            check("walk_nq", 32'(qlog.size()), 32'd3);
        end

        // tunnel: left of x=0 wraps to 27
        target_x = 5'd20; target_y = 5'd14; rsp_delay = 1;
        qlog.delete();
        exp_q.push_back({5'd27, 5'd11, 2'd3}); nexp++;
        ce_pulse(8);
        wait_steps(nexp, 40, "tunnel_step");
        check("tunnel_nq", 32'(qlog.size()), 32'd3);
        if (qlog.size() == 3) check("tunnel_q_left", 32'(qlog[1]), 32'({5'd27, 5'd11}));

        // tie-break: up and left equidistant from (26,10) -> up
        wmap[10][27] = 1'b0;
        target_x = 5'd26; target_y = 5'd10;
        qlog.delete();
        exp_q.push_back({5'd27, 5'd10, 2'd1}); nexp++;
        ce_pulse(8);
        wait_steps(nexp, 40, "tie_step");
        check("tie_nq", 32'(qlog.size()), 32'd3);

        // dead end at (27,10) heading up: reverse to down, reverse never queried
        ready_delay = 2; rsp_delay = 0;
        qlog.delete();
        exp_q.push_back({5'd27, 5'd11, 2'd2}); nexp++;
        ce_pulse(8);
        wait_steps(nexp, 60, "dead_step");
        check("dead_nq", 32'(qlog.size()), 32'd3);
        if (qlog.size() == 3) begin
            check("dead_q_up", 32'(qlog[0]), 32'({5'd27, 5'd9}));
            check("dead_q_left", 32'(qlog[1]), 32'({5'd26, 5'd10}));
            check("dead_q_right", 32'(qlog[2]), 32'({5'd0, 5'd10}));
        end

        // slow handshake; two more periods elapse during the step -> one extra step
        ready_delay = 5; rsp_delay = 3; stab_err = 0;
        qlog.delete();
        exp_q.push_back({5'd26, 5'd11, 2'd3}); nexp++;
        exp_q.push_back({5'd25, 5'd11, 2'd3}); nexp++;
        ce_burst(8);
        ce_burst(16);
        #1;
        check("hs_mid_no_step", steps_seen, nexp - 2);
        wait_steps(nexp, 200, "hs_steps");
        check("hs_stable", stab_err, 0);
        check("hs_nq", 32'(qlog.size()), 32'd6);
        repeat (80) @(negedge clk);
        #1;
        check("hs_no_third_step", steps_seen, nexp);

        // async reset in the middle of a probe
        ce_pulse(8);
        begin
            int c;
            c = 0;
            while ((qry_valid !== 1'b1) && (c < 40)) begin
                @(negedge clk); #1;
                c++;
            end
        end
        check("probe_qry_valid", 32'(qry_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_qry_valid", 32'(qry_valid), 32'd0);
        check("arst_xpos", 32'(xpos), 32'd13);
        check("arst_ypos", 32'(ypos), 32'd11);
        check("arst_dir", 32'(direction), 32'd3);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; run = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("end_idle_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("step_total", steps_seen, nexp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ghost_move_ctrl.md
Name: ghost_move_ctrl

Overview:
- Tile-grid movement controller for one ghost. Drives the xpos/ypos/direction inputs of the ghost sprite renderer.
- Every SPEED_DIV frame ticks it probes the neighbouring tiles through a shared maze-wall query port, picks the legal direction that minimises distance to a target tile, and advances one tile.
- Sits between the game-mode logic (supplies target and run) and the maze ROM arbiter (answers wall queries).

Parameters:
- SPEED_DIV, 8: ce ticks per tile step (range 1..15).
- MAZE_W, 28: maze width in tiles; x wraps modulo MAZE_W (tunnel).
- MAZE_H, 31: maze height in tiles; y never wraps.
- START_X, 13: reset x tile.
- START_Y, 11: reset y tile.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  frame tick enable, one-cycle pulse
- run  in  1  level; 1 = keep stepping
- target_x  in  5  target tile x, sampled in DECIDE
- target_y  in  5  target tile y, sampled in DECIDE
- qry_valid  out  1  wall query request
- qry_x  out  5  queried tile x
- qry_y  out  5  queried tile y
- qry_ready  in  1  arbiter accepts query this cycle
- rsp_valid  in  1  wall response valid
- rsp_wall  in  1  1 = tile is wall
- xpos  out  5  current tile x
- ypos  out  5  current tile y
- direction  out  2  0=right, 1=up, 2=down, 3=left
- busy  out  1  state != IDLE
- step_done  out  1  one-cycle pulse when a tile step commits

Behaviour:
- Reset (async, reset_n=0): xpos=START_X, ypos=START_Y, direction=3, qry_valid=0, busy=0, step_done=0, tick counter=0, pending=0, state=IDLE. qry_valid drops immediately, even mid-query; the arbiter discards any in-flight response.
- Tick counter: increments on ce in every state except IDLE. At SPEED_DIV-1 it wraps to 0 and sets pending. pending saturates at 1; extra periods during a slow decision are dropped.
- States and transitions:
  - IDLE: run=1 -> WAIT; counter cleared on entry.
  - WAIT: pending=1 -> PROBE with candidate index 0; pending cleared.
  - PROBE: walks candidates in tie-break order up(1), left(3), down(2), right(0).
    - The reverse of the current direction is skipped, with no query.
    - A neighbour with y outside 0..MAZE_H-1 is a wall, with no query.
    - Otherwise assert qry_valid with the neighbour tile (x wrapped: 0-1 -> MAZE_W-1, MAZE_W-1+1 -> 0). Hold qry_x/qry_y stable until qry_ready=1.
    - Then wait for rsp_valid and record legal=~rsp_wall. At most one query outstanding.
    - After the 4th candidate -> DECIDE.
  - DECIDE, 1 cycle:
    - For each legal candidate: dist = dx^2+dy^2, with dx/dy as 6-bit signed differences (neighbour - target), result 11 bits unsigned, max 1922.
    - Pick the minimum; equal distances go to the earlier candidate in tie-break order.
    - No legal candidate (dead end): choose the reverse direction without querying.
    - -> MOVE.
  - MOVE, 1 cycle: update direction, xpos (wrapped) and ypos; pulse step_done. Next state: run=1 -> WAIT, else -> IDLE.
- run deasserted mid-step: the current step completes, then IDLE. Position and direction hold in IDLE.
- run reasserted in IDLE: stepping resumes from the held position.
- ce coincident with MOVE still counts.
- qry_ready and rsp_valid in the same cycle as the request: accepted, and the response is taken that cycle. rsp_valid outside an outstanding query is ignored.
- Latency with an always-ready arbiter and 1-cycle response: pending -> step_done in at most 1+4*2+1+1 = 11 clk.

Test Plan:
- Open corridor, direction=3, at (13,11), target (0,11), neighbours free except down/up walls: after SPEED_DIV=8 ce ticks, one step_done and xpos=12, direction=3. Right is never queried (reverse).
- Tunnel: xpos=0, direction=3, left free, target (20,14): step -> xpos=27; qry_x=27 seen on the left probe.
- Tie-break: up and left both legal, equidistant from target -> direction=1 chosen.
- Dead end: all three non-reverse candidates walls -> direction reverses, 3 queries issued (reverse not queried), position moves back one tile.
- Handshake: qry_ready held low 5 cycles, rsp_valid 3 cycles later -> qry_x/qry_y stable throughout, one step only; 2 full SPEED_DIV periods elapse meanwhile -> only one extra step follows (pending saturates).
- Async reset asserted during PROBE with qry_valid=1 -> qry_valid=0 with no clock edge; xpos=13, ypos=11, direction=3, busy=0.
